ifft8_seq: RTL and testbench

//  8-point inverse FFT, time-multiplexed over one butterfly, one butterfly per cycle.

---
 rtl/fft_pkg.sv | 50 +++++
 rtl/ifft8_seq_bfly.sv | 43 ++++
 rtl/ifft8_seq.sv | 202 ++++++++++++++++++++
 tb/tb_ifft8_seq.sv | 308 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fft_pkg.sv
// rtl/fft_pkg.sv - shared constants, twiddle ROM, helpers and FSM state type for the 8-point IFFT
// Purpose: widths of bins/working values/outputs, Q1.15 twiddles for the inverse
//          transform (positive exponent), 3-bit bit reversal, sign extension of
//          input bins and the final divide-by-8 with saturation.
// Ports:   none (package).
package fft_pkg;

    localparam int DATA_WIDTH  = 21;
    localparam int FRAC_BITS   = 15;
    localparam int INT_WIDTH   = 24;
    localparam int OUT_WIDTH   = 16;
    localparam int TW_WIDTH    = 16;
    localparam int SCALE_SHIFT = 3;

    // W_k = cos(2*pi*k/8) + j*sin(2*pi*k/8), Q1.15; unity is 32767 because +1.0 is not representable.
    localparam logic signed [TW_WIDTH-1:0] TW_RE_K0 =  16'sd32767;
    localparam logic signed [TW_WIDTH-1:0] TW_IM_K0 =  16'sd0;
    localparam logic signed [TW_WIDTH-1:0] TW_RE_K1 =  16'sd23170;
    localparam logic signed [TW_WIDTH-1:0] TW_IM_K1 =  16'sd23170;
    localparam logic signed [TW_WIDTH-1:0] TW_RE_K2 =  16'sd0;
    localparam logic signed [TW_WIDTH-1:0] TW_IM_K2 =  16'sd32767;
    localparam logic signed [TW_WIDTH-1:0] TW_RE_K3 = -16'sd23170;
    localparam logic signed [TW_WIDTH-1:0] TW_IM_K3 =  16'sd23170;

    localparam logic signed [INT_WIDTH-1:0] OUT_MAX = INT_WIDTH'(32767);
    localparam logic signed [INT_WIDTH-1:0] OUT_MIN = INT_WIDTH'(-32768);

    typedef enum logic [1:0] {IDLE, BFLY, SCALE, DONE} state_e;

    function automatic logic [2:0] bitrev3(input logic [2:0] i);
        return {i[0], i[1], i[2]};
    endfunction

    function automatic logic [INT_WIDTH-1:0] sext_bin(input logic [DATA_WIDTH-1:0] v);
        return {{(INT_WIDTH-DATA_WIDTH){v[DATA_WIDTH-1]}}, v};
    endfunction

    // Returns {clip, value}: arithmetic >>>3 (floor), then clamp to the Q1.15 range.
    function automatic logic [OUT_WIDTH:0] scale_sat(input logic signed [INT_WIDTH-1:0] v);
        logic signed [INT_WIDTH-1:0] s;
        s = v >>> SCALE_SHIFT;
        if (s > OUT_MAX) begin
            return {1'b1, OUT_MAX[OUT_WIDTH-1:0]};
        end else if (s < OUT_MIN) begin
            return {1'b1, OUT_MIN[OUT_WIDTH-1:0]};
        end
        return {1'b0, s[OUT_WIDTH-1:0]};
    endfunction

endpackage

// File: rtl/ifft8_seq_bfly.sv
// rtl/ifft8_seq_bfly.sv - combinational radix-2 DIT butterfly with Q1.15 twiddle
// Purpose: top' = a + W*b, bot' = a - W*b. W*b keeps the full product, the
//          complex sum is then shifted >>>FRAC_BITS (floor); all sums wrap in DATA_WIDTH.
// Ports:   a_re_i/a_im_i, b_re_i/b_im_i  operands (DATA_WIDTH, signed)
//          w_re_i/w_im_i                 twiddle (TW_WIDTH, signed Q1.15)
//          top_re_o/top_im_o             a + W*b
//          bot_re_o/bot_im_o             a - W*b
module ifft8_seq_bfly #(
    parameter int DATA_WIDTH = 24,
    parameter int FRAC_BITS  = 15,
    parameter int TW_WIDTH   = 16
) (
    input  logic signed [DATA_WIDTH-1:0] a_re_i,
    input  logic signed [DATA_WIDTH-1:0] a_im_i,
    input  logic signed [DATA_WIDTH-1:0] b_re_i,
    input  logic signed [DATA_WIDTH-1:0] b_im_i,
    input  logic signed [TW_WIDTH-1:0]   w_re_i,
    input  logic signed [TW_WIDTH-1:0]   w_im_i,
    output logic signed [DATA_WIDTH-1:0] top_re_o,
    output logic signed [DATA_WIDTH-1:0] top_im_o,
    output logic signed [DATA_WIDTH-1:0] bot_re_o,
    output logic signed [DATA_WIDTH-1:0] bot_im_o
);

    localparam int PW = DATA_WIDTH + TW_WIDTH + 1;

    logic signed [PW-1:0]         p_re;
    logic signed [PW-1:0]         p_im;
    logic signed [DATA_WIDTH-1:0] t_re;
    logic signed [DATA_WIDTH-1:0] t_im;

    assign p_re = PW'(b_re_i) * PW'(w_re_i) - PW'(b_im_i) * PW'(w_im_i);
    assign p_im = PW'(b_re_i) * PW'(w_im_i) + PW'(b_im_i) * PW'(w_re_i);

    assign t_re = DATA_WIDTH'(p_re >>> FRAC_BITS);
    assign t_im = DATA_WIDTH'(p_im >>> FRAC_BITS);

    assign top_re_o = a_re_i + t_re;
    assign top_im_o = a_im_i + t_im;
    assign bot_re_o = a_re_i - t_re;
    assign bot_im_o = a_im_i - t_im;

endmodule

// File: rtl/ifft8_seq.sv
// rtl/ifft8_seq.sv - 8-point inverse FFT, one shared butterfly, one butterfly per cycle
// Purpose: accepts 8 Q5.15 bins, runs 3 in-place DIT stages (12 cycles) over a
//          bit-reversed register file, then divides by 8 with saturation into Q1.15.
// Ports:   clk_i, rst_ni (async, active low)
//          valid_i/ready_o, y_re_i/y_im_i [0:7]  input frame handshake and bins
//          valid_o/ready_i, x_re_o/x_im_o [0:7]  output frame handshake and samples
//          sat_o                                 some output of this frame was clipped
module ifft8_seq
    import fft_pkg::*;
(
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  valid_i,
    output logic                  ready_o,
    input  logic [DATA_WIDTH-1:0] y_re_i [0:7],
    input  logic [DATA_WIDTH-1:0] y_im_i [0:7],
    output logic                  valid_o,
    input  logic                  ready_i,
    output logic [OUT_WIDTH-1:0]  x_re_o [0:7],
    output logic [OUT_WIDTH-1:0]  x_im_o [0:7],
    output logic                  sat_o
);

    state_e                      state_q, state_d;
    logic [3:0]                  cnt_q, cnt_d;
    logic signed [INT_WIDTH-1:0] mem_re_q [0:7];
    logic signed [INT_WIDTH-1:0] mem_im_q [0:7];
    logic [OUT_WIDTH-1:0]        x_re_q [0:7];
    logic [OUT_WIDTH-1:0]        x_im_q [0:7];
    logic                        sat_q;

    logic                        load_en, bfly_en, scale_en;
    logic [1:0]                  stage, bidx, tw_k;
    logic [2:0]                  top_idx, bot_idx;
    logic signed [TW_WIDTH-1:0]  w_re, w_im;
    logic signed [INT_WIDTH-1:0] bf_top_re, bf_top_im, bf_bot_re, bf_bot_im;
    logic [OUT_WIDTH:0]          sc_re [0:7];
    logic [OUT_WIDTH:0]          sc_im [0:7];
    logic                        clip_any;

    // State register
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state logic; cnt_q walks the 12 butterflies, stage in [3:2], butterfly in [1:0]
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (valid_i) begin
                    state_d = BFLY;
                    cnt_d   = '0;
                end
            end
            BFLY: begin
                if (cnt_q == 4'd11) begin
                    state_d = SCALE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            SCALE:   state_d = DONE;
            DONE:    if (ready_i) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Output / enable decode
    always_comb begin
        ready_o  = 1'b0;
        valid_o  = 1'b0;
        load_en  = 1'b0;
        bfly_en  = 1'b0;
        scale_en = 1'b0;
        case (state_q)
            IDLE: begin
                ready_o = 1'b1;
                load_en = valid_i;
            end
            BFLY:    bfly_en  = 1'b1;
            SCALE:   scale_en = 1'b1;
            DONE:    valid_o  = 1'b1;
            default: ;
        endcase
    end

    // Operand addressing. With span = 1<<s, top = ((b>>s)<<(s+1)) + (b & (span-1))
    // reduces to inserting a 0 (top) or 1 (bot) at bit position s of the butterfly index.
    assign stage = cnt_q[3:2];
    assign bidx  = cnt_q[1:0];

    always_comb begin
        top_idx = '0;
        bot_idx = '0;
        tw_k    = '0;
        case (stage)
            2'd0: begin
                top_idx = {bidx, 1'b0};
                bot_idx = {bidx, 1'b1};
                tw_k    = 2'd0;
            end
            2'd1: begin
                top_idx = {bidx[1], 1'b0, bidx[0]};
                bot_idx = {bidx[1], 1'b1, bidx[0]};
                tw_k    = {bidx[0], 1'b0};
            end
            default: begin
                top_idx = {1'b0, bidx};
                bot_idx = {1'b1, bidx};
                tw_k    = bidx;
            end
        endcase
    end

    always_comb begin
        w_re = TW_RE_K0;
        w_im = TW_IM_K0;
        case (tw_k)
            2'd1: begin w_re = TW_RE_K1; w_im = TW_IM_K1; end
            2'd2: begin w_re = TW_RE_K2; w_im = TW_IM_K2; end
            2'd3: begin w_re = TW_RE_K3; w_im = TW_IM_K3; end
            default: ;
        endcase
    end

    ifft8_seq_bfly #(
        .DATA_WIDTH (INT_WIDTH),
        .FRAC_BITS  (FRAC_BITS),
        .TW_WIDTH   (TW_WIDTH)
    ) u_bfly (
        .a_re_i   (mem_re_q[top_idx]),
        .a_im_i   (mem_im_q[top_idx]),
        .b_re_i   (mem_re_q[bot_idx]),
        .b_im_i   (mem_im_q[bot_idx]),
        .w_re_i   (w_re),
        .w_im_i   (w_im),
        .top_re_o (bf_top_re),
        .top_im_o (bf_top_im),
        .bot_re_o (bf_bot_re),
        .bot_im_o (bf_bot_im)
    );

    always_comb begin
        clip_any = 1'b0;
        for (int i = 0; i < 8; i++) begin
            sc_re[i] = scale_sat(mem_re_q[i]);
            sc_im[i] = scale_sat(mem_im_q[i]);
            clip_any = clip_any | sc_re[i][OUT_WIDTH] | sc_im[i][OUT_WIDTH];
        end
    end

    // Register file: bit-reversed load, in-place butterfly write-back
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < 8; i++) begin
                mem_re_q[i] <= '0;
                mem_im_q[i] <= '0;
            end
        end else if (load_en) begin
            for (int i = 0; i < 8; i++) begin
                mem_re_q[i] <= sext_bin(y_re_i[bitrev3(3'(i))]);
                mem_im_q[i] <= sext_bin(y_im_i[bitrev3(3'(i))]);
            end
        end else if (bfly_en) begin
            mem_re_q[top_idx] <= bf_top_re;
            mem_im_q[top_idx] <= bf_top_im;
            mem_re_q[bot_idx] <= bf_bot_re;
            mem_im_q[bot_idx] <= bf_bot_im;
        end
    end

    // Output registers hold their value until the next SCALE cycle
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < 8; i++) begin
                x_re_q[i] <= '0;
                x_im_q[i] <= '0;
            end
            sat_q <= 1'b0;
        end else if (scale_en) begin
            for (int i = 0; i < 8; i++) begin
                x_re_q[i] <= sc_re[i][OUT_WIDTH-1:0];
                x_im_q[i] <= sc_im[i][OUT_WIDTH-1:0];
            end
            sat_q <= clip_any;
        end
    end

    assign x_re_o = x_re_q;
    assign x_im_o = x_im_q;
    assign sat_o  = sat_q;

endmodule

// File: tb/tb_ifft8_seq.sv
// tb/tb_ifft8_seq.sv - self-checking bench for ifft8_seq against a textbook DIT reference
module tb_ifft8_seq;

    logic        clk_i = 1'b0;
    logic        rst_n;
    logic        valid_i;
    logic        ready_o;
    logic [20:0] y_re_i [0:7];
    logic [20:0] y_im_i [0:7];
    logic        valid_o;
    logic        ready_i;
    logic [15:0] x_re_o [0:7];
    logic [15:0] x_im_o [0:7];
    logic        sat_o;

    ifft8_seq dut (
        .clk_i   (clk_i),
        .rst_ni  (rst_n),
        .valid_i (valid_i),
        .ready_o (ready_o),
        .y_re_i  (y_re_i),
        .y_im_i  (y_im_i),
        .valid_o (valid_o),
        .ready_i (ready_i),
        .x_re_o  (x_re_o),
        .x_im_o  (x_im_o),
        .sat_o   (sat_o)
    );

    always #5 clk_i = ~clk_i;

    int     n_checks = 0;
    int     n_fail   = 0;
    longint yre [8];
    longint yim [8];
    longint ere [8];
    longint eim [8];
    bit     esat;
    longint twr [4] = '{32767, 23170, 0, -23170};
    longint twi [4] = '{0, 23170, 32767, 23170};
    longint cos_exp [8] = '{16384, 11585, 0, -11585, -16384, -11585, 0, 11585};
    longint xorig [8];
    longint last_hs = 0;
    longint hs_period = 0;
    int     lat;

    task automatic check_val(input string tag, input longint got, input longint exp, input longint tol = 0);
        n_checks++;
        if (got > exp + tol || got < exp - tol) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (tol %0d)", tag, got, exp, tol);
        end
    endtask

    function automatic longint sx(input logic [15:0] v);
        return longint'($signed(v));
    endfunction

    task automatic clear_bins();
        for (int i = 0; i < 8; i++) begin
            yre[i] = 0;
            yim[i] = 0;
        end
    endtask

    // Iterative radix-2 DIT over a bit-reversed copy, then floor(/8) and clamp.
    task automatic model_ifft();
        longint ar [8];
        longint ai [8];
        longint tr, ti, v;
        int     k, t, b, src;
        for (int i = 0; i < 8; i++) begin
            src   = ((i & 1) << 2) | (i & 2) | ((i >> 2) & 1);
            ar[i] = yre[src];
            ai[i] = yim[src];
        end
        for (int span = 1; span < 8; span = span * 2) begin
            for (int g = 0; g < 8; g = g + 2 * span) begin
                for (int j = 0; j < span; j++) begin
                    k  = j * (4 / span);
                    t  = g + j;
                    b  = t + span;
                    tr = (ar[b] * twr[k] - ai[b] * twi[k]) >>> 15;
                    ti = (ar[b] * twi[k] + ai[b] * twr[k]) >>> 15;
                    ar[b] = ar[t] - tr;
                    ai[b] = ai[t] - ti;
                    ar[t] = ar[t] + tr;
                    ai[t] = ai[t] + ti;
                end
            end
        end
        esat = 1'b0;
        for (int i = 0; i < 8; i++) begin
            v = ar[i] >>> 3;
            if (v > 32767) begin v = 32767; esat = 1'b1; end
            if (v < -32768) begin v = -32768; esat = 1'b1; end
            ere[i] = v;
            v = ai[i] >>> 3;
            if (v > 32767) begin v = 32767; esat = 1'b1; end
            if (v < -32768) begin v = -32768; esat = 1'b1; end
            eim[i] = v;
        end
    endtask

    task automatic send_frame();
        int n = 0;
        @(negedge clk_i);
        while (!ready_o && n < 50) begin
            @(negedge clk_i);
            n++;
        end
        check_val("ready_before_send", longint'(ready_o), 1);
        for (int i = 0; i < 8; i++) begin
            y_re_i[i] = 21'(yre[i]);
            y_im_i[i] = 21'(yim[i]);
        end
        valid_i = 1'b1;
        @(posedge clk_i);
        hs_period = ($time - last_hs) / 10;
        last_hs   = $time;
        @(negedge clk_i);
        valid_i = 1'b0;
    endtask

    task automatic wait_out(output int l);
        l = 0;
        while (!valid_o && l < 40) begin
            @(posedge clk_i);
            @(negedge clk_i);
            l++;
        end
        check_val("valid_o_timeout", longint'(valid_o), 1);
    endtask

    task automatic check_frame(input string tag);
        for (int i = 0; i < 8; i++) begin
            check_val($sformatf("%s_re%0d", tag, i), sx(x_re_o[i]), ere[i]);
            check_val($sformatf("%s_im%0d", tag, i), sx(x_im_o[i]), eim[i]);
        end
        check_val({tag, "_sat"}, longint'(sat_o), longint'(esat));
    endtask

    task automatic run_frame(input string tag);
        model_ifft();
        send_frame();
        wait_out(lat);
        check_val({tag, "_latency"}, lat, 13);
        check_frame(tag);
    endtask

    task automatic cos_bins();
        clear_bins();
        yre[1] = 65536;
        yre[7] = 65536;
    endtask

    task automatic check_cos(input string tag);
        for (int i = 0; i < 8; i++) begin
            check_val($sformatf("%s_ideal_re%0d", tag, i), sx(x_re_o[i]), cos_exp[i], 2);
            check_val($sformatf("%s_ideal_im%0d", tag, i), sx(x_im_o[i]), 0, 2);
        end
    endtask

    initial begin
        rst_n   = 1'b0;
        valid_i = 1'b0;
        ready_i = 1'b1;
        for (int i = 0; i < 8; i++) begin
            y_re_i[i] = '0;
            y_im_i[i] = '0;
        end
        repeat (3) @(negedge clk_i);
        check_val("rst_ready_o", longint'(ready_o), 1);
        check_val("rst_valid_o", longint'(valid_o), 0);
        check_val("rst_sat_o", longint'(sat_o), 0);
        for (int i = 0; i < 8; i++) begin
            check_val($sformatf("rst_x_re%0d", i), sx(x_re_o[i]), 0);
            check_val($sformatf("rst_x_im%0d", i), sx(x_im_o[i]), 0);
        end
        rst_n = 1'b1;

        // DC bin
        clear_bins();
        yre[0] = 131072;
        run_frame("dc");
        for (int i = 0; i < 8; i++) begin
            check_val($sformatf("dc_ideal_re%0d", i), sx(x_re_o[i]), 16384);
            check_val($sformatf("dc_ideal_im%0d", i), sx(x_im_o[i]), 0);
        end
        check_val("dc_ideal_sat", longint'(sat_o), 0);

        // Cosine from a conjugate-symmetric pair
        cos_bins();
        run_frame("cos");
        check_cos("cos");

        // Saturation, then a clean frame clears sat_o
        clear_bins();
        yre[0] = 1048575;
        run_frame("satur");
        for (int i = 0; i < 8; i++) begin
            check_val($sformatf("satur_ideal_re%0d", i), sx(x_re_o[i]), 32767);
            check_val($sformatf("satur_ideal_im%0d", i), sx(x_im_o[i]), 0);
        end
        check_val("satur_ideal_sat", longint'(sat_o), 1);
        clear_bins();
        yre[0] = 131072;
        run_frame("dc_after_sat");
        check_val("dc_after_sat_ideal_sat", longint'(sat_o), 0);

        // Random frames against the reference model, alternating magnitude ranges
        for (int f = 0; f < 16; f++) begin
            for (int i = 0; i < 8; i++) begin
                if (f % 2 == 0) begin
                    yre[i] = longint'($signed(21'($urandom)));
                    yim[i] = longint'($signed(21'($urandom)));
                end else begin
                    yre[i] = longint'($urandom_range(0, 65535)) - 32768;
                    yim[i] = longint'($urandom_range(0, 65535)) - 32768;
                end
            end
            run_frame($sformatf("rand%0d", f));
        end

        // Backpressure: outputs hold, valid_i pulses ignored while DONE
        for (int i = 0; i < 8; i++) begin
            yre[i] = longint'($urandom_range(0, 200000)) - 100000;
            yim[i] = longint'($urandom_range(0, 200000)) - 100000;
        end
        model_ifft();
        send_frame();
        ready_i = 1'b0;
        wait_out(lat);
        check_val("bp_latency", lat, 13);
        check_frame("bp");
        for (int c = 0; c < 20; c++) begin
            valid_i = c[0];
            for (int i = 0; i < 8; i++) begin
                y_re_i[i] = 21'($urandom);
                y_im_i[i] = 21'($urandom);
            end
            @(negedge clk_i);
            check_val("bp_valid_o_held", longint'(valid_o), 1);
            check_val("bp_ready_o_low", longint'(ready_o), 0);
            check_frame("bp_hold");
        end
        valid_i = 1'b0;
        ready_i = 1'b1;
        @(negedge clk_i);
        check_val("bp_release_ready_o", longint'(ready_o), 1);
        check_val("bp_release_valid_o", longint'(valid_o), 0);
        check_frame("bp_after_accept");

        // Reset in the middle of the butterfly phase
        cos_bins();
        send_frame();
        repeat (5) @(negedge clk_i);
        rst_n = 1'b0;
        @(negedge clk_i);
        check_val("midrst_valid_o", longint'(valid_o), 0);
        check_val("midrst_ready_o", longint'(ready_o), 1);
        check_val("midrst_sat_o", longint'(sat_o), 0);
        rst_n = 1'b1;
        for (int c = 0; c < 16; c++) begin
            @(negedge clk_i);
            check_val("midrst_no_valid", longint'(valid_o), 0);
            check_val("midrst_idle_ready", longint'(ready_o), 1);
        end
        cos_bins();
        run_frame("cos_after_rst");
        check_cos("cos_after_rst");

        // Round trip through a floating-point forward FFT, back-to-back frames
        for (int f = 0; f < 4; f++) begin
            real re_acc, im_acc, ang;
            for (int n = 0; n < 8; n++) begin
                xorig[n] = longint'($urandom_range(0, 60000)) - 30000;
            end
            for (int k = 0; k < 8; k++) begin
                re_acc = 0.0;
                im_acc = 0.0;
                for (int n = 0; n < 8; n++) begin
                    ang    = 2.0 * 3.14159265358979 * real'(k * n) / 8.0;
                    re_acc = re_acc + real'(xorig[n]) * $cos(ang);
                    im_acc = im_acc - real'(xorig[n]) * $sin(ang);
                end
                yre[k] = longint'(re_acc);
                yim[k] = longint'(im_acc);
            end
            model_ifft();
            send_frame();
            if (f > 0) begin
                check_val($sformatf("rt%0d_period", f), hs_period, 15);
            end
            wait_out(lat);
            check_val($sformatf("rt%0d_latency", f), lat, 13);
            check_frame($sformatf("rt%0d", f));
            for (int i = 0; i < 8; i++) begin
                check_val($sformatf("rt%0d_orig_re%0d", f, i), sx(x_re_o[i]), xorig[i], 4);
                check_val($sformatf("rt%0d_orig_im%0d", f, i), sx(x_im_o[i]), 0, 4);
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
